hilo_unit: RTL

Execute-stage HI/LO register block with an iterative 32x32 multiplier. It sits directly downstream of the ALU decoder. E-stage glue turns the decoder's HI/LO control outputs (write, select, ifhilo) into the mult/mthi/mtlo strobes below. The block holds the architectural HI and LO registers, runs MULT/MULTU over 33 stall cycles, and exposes HI/LO for MFHI/MFLO.

---
 rtl/hilo_unit_pkg.sv | 13 +
 rtl/hilo_unit_mul_iter.sv | 35 +++
 rtl/hilo_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register block and its iterative multiplier.
package hilo_unit_pkg;

    localparam int MULT_CYCLES = 32;
    localparam int CNT_W       = $clog2(MULT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_unit_mul_iter.sv
// Sequential shift-add core: one multiplier bit per step, LSB first, 2*WIDTH accumulator.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO registers with a 33-cycle iterative MULT/MULTU and pipeline stall.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               negate;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;

    // Signed operands are reduced to magnitudes; the sign is reapplied once at DONE.
    assign mag_a = (signed_i && srca_i[WIDTH-1]) ? -srca_i : srca_i;
    assign mag_b = (signed_i && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

    assign load    = (state == IDLE) && start_i && !flush_i;
    assign step    = (state == RUN)  && start_i && !flush_i;
    assign product = negate ? -acc : acc;

    // Reset also releases the stall so the pipeline is not frozen while held in reset.
    assign stall_o = start_i && (state != DONE) && !flush_i && !rst;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a    (mag_a),
        .b    (mag_b),
        .acc  (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            count  <= '0;
            negate <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        count  <= '0;
                        negate <= signed_i && (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
                    end else if (!start_i && !flush_i) begin
                        if (mthi_i) hi_o <= srca_i;
                        if (mtlo_i) lo_o <= srca_i;
                    end
                end
                RUN: begin
                    if (flush_i || !start_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(MULT_CYCLES - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (start_i && !flush_i) begin
                        hi_o <= product[2*WIDTH-1:WIDTH];
                        lo_o <= product[WIDTH-1:0];
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
